// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | issue_ctrl_pkg : shared types for the in-order issue controller             |
// | Entry fields widen when ISSUE_SCOREBOARD_EN is defined.                     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package issue_ctrl_pkg;

  localparam int ISSUE_DEPTH = 2;
  localparam int XU_COUNT    = 6;

  typedef enum logic [2:0] {
    XU_BYPASS  = 3'd0,
    XU_ADDER   = 3'd1,
    XU_LOGICAL = 3'd2,
    XU_SHIFTER = 3'd3,
    XU_BRANCH  = 3'd4,
    XU_MEMORY  = 3'd5
  } xu_e;

  typedef struct packed {
    xu_e        xu;
    logic [3:0] tag;
`ifdef ISSUE_SCOREBOARD_EN
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
`endif
  } iq_entry_t;

  function automatic logic [XU_COUNT-1:0] xu_onehot(input xu_e xu);
    logic [XU_COUNT-1:0] v;
    v = '0;
    for (int i = 0; i < XU_COUNT; i++) begin
      if (int'(xu) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Encodings beyond XU_COUNT have no busy bit and are treated as free.
  function automatic logic xu_is_busy(input xu_e xu, input logic [XU_COUNT-1:0] busy);
    logic b;
    b = 1'b0;
    for (int i = 0; i < XU_COUNT; i++) begin
      if (int'(xu) == i) b = busy[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | issue_scoreboard : 32-entry pending-write mask with hazard lookup           |
// | Only instantiated when ISSUE_SCOREBOARD_EN is defined.                      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module issue_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       hazard
);

  logic [31:0] r_pending;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en && set_idx != 5'd0) w_set_mask[set_idx] = 1'b1;
    if (clr_en)                    w_clr_mask[clr_idx] = 1'b1;
  end

  // Set is applied after clear so a same-index set wins; register 0 never pends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'h1;
    end
  end

  assign hazard = r_pending[rs1] | r_pending[rs2] | r_pending[rd];

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | issue_ctrl : 2-entry in-order issue buffer with squash, stall counting and  |
// | optional register scoreboard (ISSUE_SCOREBOARD_EN).                         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [2:0]          dec_xu,
  input  logic [3:0]          dec_tag,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic [4:0]          dec_rd,
  input  logic [3:0]          cur_tag,
  input  logic [XU_COUNT-1:0] xu_busy,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic                iss_valid,
  output logic [2:0]          iss_xu,
  output logic [3:0]          iss_tag,
  output logic [XU_COUNT-1:0] iss_sel,
  output logic [15:0]         stall_cnt
);

  iq_entry_t           r_ent [ISSUE_DEPTH];
  logic [1:0]          r_count;
  logic                r_iss_valid;
  xu_e                 r_iss_xu;
  logic [3:0]          r_iss_tag;
  logic [XU_COUNT-1:0] r_iss_sel;
  logic [15:0]         r_stall_cnt;

  iq_entry_t w_head;
  iq_entry_t w_new;
  logic      w_head_vld;
  logic      w_tag_match;
  logic      w_unit_free;
  logic      w_hazard;
  logic      w_squash;
  logic      w_issue;
  logic      w_block;
  logic      w_push;
  logic      w_pop;

  assign dec_ready   = (r_count != 2'(ISSUE_DEPTH));
  assign w_head      = r_ent[0];
  assign w_head_vld  = (r_count != 2'd0);
  assign w_tag_match = (w_head.tag == cur_tag);
  assign w_unit_free = (w_head.xu == XU_BYPASS) || !xu_is_busy(w_head.xu, xu_busy);

  assign w_squash = w_head_vld && !w_tag_match;
  assign w_issue  = w_head_vld &&  w_tag_match &&  (w_unit_free && !w_hazard);
  assign w_block  = w_head_vld &&  w_tag_match && !(w_unit_free && !w_hazard);
  assign w_pop    = w_squash || w_issue;
  assign w_push   = dec_valid && dec_ready;

  always_comb begin
    w_new     = '0;
    w_new.xu  = xu_e'(dec_xu);
    w_new.tag = dec_tag;
`ifdef ISSUE_SCOREBOARD_EN
    w_new.rs1 = dec_rs1;
    w_new.rs2 = dec_rs2;
    w_new.rd  = dec_rd;
`endif
  end

`ifdef ISSUE_SCOREBOARD_EN
  issue_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (w_issue),
    .set_idx (w_head.rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .rs1     (w_head.rs1),
    .rs2     (w_head.rs2),
    .rd      (w_head.rd),
    .hazard  (w_hazard)
  );
`else
  logic w_unused;
  assign w_unused = ^{wb_valid, wb_rd, dec_rs1, dec_rs2, dec_rd};
  assign w_hazard = 1'b0;
`endif

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_ent[r_count[0]] <= w_new;
          r_count           <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent[0] <= r_ent[1];
          r_count  <= r_count - 2'd1;
        end
        2'b11:   r_ent[0] <= w_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_valid <= 1'b0;
      r_iss_sel   <= '0;
      r_iss_xu    <= XU_BYPASS;
      r_iss_tag   <= 4'd0;
    end else begin
      r_iss_valid <= w_issue;
      r_iss_sel   <= w_issue ? xu_onehot(w_head.xu) : '0;
      if (w_issue) begin
        r_iss_xu  <= w_head.xu;
        r_iss_tag <= w_head.tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_block && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_xu    = r_iss_xu;
  assign iss_tag   = r_iss_tag;
  assign iss_sel   = r_iss_sel;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_issue_ctrl : vector table, directed corner sequences and random stimulus |
// | against a queue-based reference model. Honors ISSUE_SCOREBOARD_EN.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_xu;
  logic [3:0]  dec_tag;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [3:0]  cur_tag;
  logic [5:0]  xu_busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        iss_valid;
  logic [2:0]  iss_xu;
  logic [3:0]  iss_tag;
  logic [5:0]  iss_sel;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_xu    (dec_xu),
    .dec_tag   (dec_tag),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .dec_rd    (dec_rd),
    .cur_tag   (cur_tag),
    .xu_busy   (xu_busy),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .iss_valid (iss_valid),
    .iss_xu    (iss_xu),
    .iss_tag   (iss_tag),
    .iss_sel   (iss_sel),
    .stall_cnt (stall_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending instructions plus plain counters.
  typedef struct {
    int xu;
    int tag;
    int rs1;
    int rs2;
    int rd;
  } ent_t;

  ent_t mq[$];
  int   m_stall = 0;
  bit   m_pend[32];
  bit   m_v = 0;
  int   m_xu = 0;
  int   m_tag = 0;

  task automatic tick();
    bit   issued;
    bit   ready;
    bit   haz;
    ent_t h;
    ent_t n;
    issued = 0;
    haz    = 0;
    h      = '{0, 0, 0, 0, 0};
    ready  = (mq.size() < 2);
    if (reset) begin
      mq.delete();
      m_stall = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_v = 0; m_xu = 0; m_tag = 0;
    end else begin
      if (mq.size() > 0) begin
        h = mq[0];
`ifdef ISSUE_SCOREBOARD_EN
        haz = m_pend[h.rs1] || m_pend[h.rs2] || m_pend[h.rd];
`endif
        if (h.tag != int'(cur_tag)) begin
          void'(mq.pop_front());
        end else if ((h.xu == 0 || xu_busy[h.xu] == 1'b0) && !haz) begin
          void'(mq.pop_front());
          issued = 1;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end
      if (dec_valid && ready) begin
        n = '{int'(dec_xu), int'(dec_tag), int'(dec_rs1), int'(dec_rs2), int'(dec_rd)};
        mq.push_back(n);
      end
`ifdef ISSUE_SCOREBOARD_EN
      if (wb_valid) m_pend[wb_rd] = 0;
      if (issued && h.rd != 0) m_pend[h.rd] = 1;
`endif
      m_v = issued;
      if (issued) begin
        m_xu  = h.xu;
        m_tag = h.tag;
      end
    end
    @(posedge clk);
    #1;
    check("iss_valid", {31'd0, iss_valid}, {31'd0, m_v});
    check("iss_sel",   {26'd0, iss_sel},   m_v ? (32'd1 << m_xu) : 32'd0);
    check("iss_xu",    {29'd0, iss_xu},    m_xu);
    check("iss_tag",   {28'd0, iss_tag},   m_tag);
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
    check("dec_ready", {31'd0, dec_ready}, {31'd0, (mq.size() < 2)});
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_xu = 0; dec_tag = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    xu_busy = 0; wb_valid = 0; wb_rd = 0;
  endtask

  typedef struct {
    bit         dv;
    int         xu;
    int         tag;
    logic [5:0] busy;
    bit         ev;
    int         exu;
    int         etag;
    int         esel;
    bit         erdy;
    int         estall;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // single adder issue, then memory head held off by a busy unit
    tbl[0]  = '{1, 1, 3, 6'h00, 0, 0, 0, 0,  1, 0};
    tbl[1]  = '{0, 0, 0, 6'h00, 1, 1, 3, 2,  1, 0};
    tbl[2]  = '{0, 0, 0, 6'h00, 0, 1, 3, 0,  1, 0};
    tbl[3]  = '{1, 5, 3, 6'h20, 0, 1, 3, 0,  1, 0};
    tbl[4]  = '{1, 5, 3, 6'h20, 0, 1, 3, 0,  0, 1};
    tbl[5]  = '{1, 5, 3, 6'h20, 0, 1, 3, 0,  0, 2};
    tbl[6]  = '{0, 0, 0, 6'h20, 0, 1, 3, 0,  0, 3};
    tbl[7]  = '{0, 0, 0, 6'h20, 0, 1, 3, 0,  0, 4};
    tbl[8]  = '{0, 0, 0, 6'h00, 1, 5, 3, 32, 1, 4};
    tbl[9]  = '{0, 0, 0, 6'h00, 1, 5, 3, 32, 1, 4};
    tbl[10] = '{0, 0, 0, 6'h00, 0, 5, 3, 0,  1, 4};

    idle_inputs();
    reset = 1; cur_tag = 3;
    tick();
    check("rst_valid", {31'd0, iss_valid}, 32'd0);
    check("rst_ready", {31'd0, dec_ready}, 32'd1);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      dec_valid = tbl[i].dv;
      dec_xu    = 3'(tbl[i].xu);
      dec_tag   = 4'(tbl[i].tag);
      xu_busy   = tbl[i].busy;
      tick();
      check("tbl_valid", {31'd0, iss_valid}, {31'd0, tbl[i].ev});
      check("tbl_xu",    {29'd0, iss_xu},    tbl[i].exu);
      check("tbl_tag",   {28'd0, iss_tag},   tbl[i].etag);
      check("tbl_sel",   {26'd0, iss_sel},   tbl[i].esel);
      check("tbl_ready", {31'd0, dec_ready}, {31'd0, tbl[i].erdy});
      check("tbl_stall", {16'd0, stall_cnt}, tbl[i].estall);
    end

    // squash: two blocked tag-2 entries dropped once cur_tag moves on
    idle_inputs();
    cur_tag = 2; xu_busy = 6'h3F;
    dec_valid = 1; dec_xu = 1; dec_tag = 2;
    tick();
    tick();
    check("sq_full", {31'd0, dec_ready}, 32'd0);
    check("sq_stall0", {16'd0, stall_cnt}, 32'd5);
    dec_valid = 0; cur_tag = 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sq_valid", {31'd0, iss_valid}, 32'd0);
      check("sq_stall", {16'd0, stall_cnt}, 32'd5);
      check("sq_ready", {31'd0, dec_ready}, 32'd1);
    end

    // reset with a full buffer discards both entries
    dec_valid = 1; dec_xu = 1; dec_tag = 4;
    tick();
    tick();
    dec_valid = 0;
    tick();
    check("rs_full", {31'd0, dec_ready}, 32'd0);
    reset = 1; xu_busy = 0;
    tick();
    reset = 0;
    check("rs_ready", {31'd0, dec_ready}, 32'd1);
    check("rs_stall", {16'd0, stall_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rs_noiss", {31'd0, iss_valid}, 32'd0);
    end

`ifdef ISSUE_SCOREBOARD_EN
    // RAW hazard on r7 released by writeback
    idle_inputs();
    cur_tag = 4;
    dec_valid = 1; dec_xu = 1; dec_tag = 4; dec_rd = 7;
    tick();
    dec_xu = 2; dec_rd = 0; dec_rs1 = 7;
    tick();
    check("sb_first", {31'd0, iss_valid}, 32'd1);
    dec_valid = 0; dec_rs1 = 0;
    tick();
    tick();
    check("sb_blocked", {31'd0, iss_valid}, 32'd0);
    wb_valid = 1; wb_rd = 7;
    tick();
    check("sb_wb_k", {31'd0, iss_valid}, 32'd0);
    wb_valid = 0;
    tick();
    check("sb_issue", {31'd0, iss_valid}, 32'd1);
    check("sb_xu",    {29'd0, iss_xu},    32'd2);
`endif

    // randomized traffic against the model
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) cur_tag = 4'($urandom_range(0, 2));
      dec_valid = ($urandom_range(0, 2) != 0);
      dec_xu    = 3'($urandom_range(0, 5));
      dec_tag   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 2)) : cur_tag;
      xu_busy   = 6'($urandom & $urandom);
      dec_rs1   = 5'($urandom_range(0, 7));
      dec_rs2   = 5'($urandom_range(0, 7));
      dec_rd    = 5'($urandom_range(0, 7));
      wb_valid  = ($urandom_range(0, 3) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      tick();
    end

    // saturation of the stall counter
    idle_inputs();
    reset = 1;
    tick();
    reset = 0; cur_tag = 1; xu_busy = 6'h3F;
    dec_valid = 1; dec_xu = 1; dec_tag = 1;
    tick();
    dec_valid = 0;
    for (int i = 0; i < 65540; i++) tick();
    check("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
    tick();
    check("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 clk  input  1  single core clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 dec_valid  input  1  decoded instruction present.
REQ-004 dec_ready  output  1  buffer can accept; transfer when dec_valid & dec_ready at a rising edge.
REQ-005 dec_xu  input  xu  target execution unit (bypass, adder, logical, shifter, branch, memory).
REQ-006 dec_tag  input  4  instruction tag.
REQ-007 dec_rs1, dec_rs2, dec_rd  input  5 each  register indices; index 0 means none.
REQ-008 cur_tag  input  4  current valid tag; a mismatching instruction is squashed.
REQ-009 xu_busy  input  6  one bit per xu, indexed by xu encoding; high means the unit cannot accept.
REQ-010 wb_valid, wb_rd  input  1, 5  writeback completion for register wb_rd.
REQ-011 iss_valid  output  1  registered one-cycle issue pulse.
REQ-012 iss_xu, iss_tag  output  xu, 4  registered fields of the issued instruction.
REQ-013 iss_sel  output  6  registered one-hot of iss_xu, all zero when iss_valid is low.
REQ-014 stall_cnt  output  16  saturating count of blocked-head cycles.

Function
REQ-015 Buffer: 2-entry in-order FIFO of {xu, tag, rs1, rs2, rd}; occupancy 0/1/2.
REQ-016 dec_ready = occupancy < 2, from registered occupancy only; when full no push, even if a pop occurs that cycle.
REQ-017 Pushed entry becomes head no earlier than the next cycle; minimum dec-to-iss_valid latency is 2 cycles.
REQ-018 Head squash: head valid and tag != cur_tag -> pop without issue; iss_valid stays low; no scoreboard update.
REQ-019 Head issue: head valid, tag == cur_tag, (xu == bypass or xu_busy[xu] == 0), no hazard -> pop; next cycle iss_valid=1 with head fields.
REQ-020 Blocked: head valid, tag match, issue condition false -> hold head; stall_cnt increments, saturating at 16'hFFFF.
REQ-021 At most one pop per cycle; simultaneous push and pop at occupancy 1 leaves occupancy 1 with new entry at head.
REQ-022 iss_valid low whenever no issue occurred in the previous cycle; iss_xu/iss_tag hold last issued values.
REQ-023 cur_tag change applies the same cycle to the head; already-issued instructions are unaffected.

Reset
REQ-024 reset high at an edge: occupancy 0, scoreboard cleared, iss_valid 0, iss_sel 0, iss_xu bypass, iss_tag 0, stall_cnt 0; dec_ready 1 the following cycle.
REQ-025 Reset mid-operation discards buffered entries without issuing them; reset overrides every simultaneous push, pop, or writeback.

Configuration
REQ-026 Macro ISSUE_SCOREBOARD_EN compiled in: a 32-bit pending mask; issue of rd != 0 sets bit rd; wb_valid clears bit wb_rd; set wins over a simultaneous clear of the same index; a hazard exists if head rs1, rs2, or rd has its bit set in the registered mask (no same-cycle writeback bypass); bit 0 is never set.
REQ-027 Macro absent: no mask, no hazard term; wb_valid and wb_rd are ignored; dec_rs1, dec_rs2, dec_rd are not stored.

Structure
REQ-028 xu typedef and its encoding, ISSUE_DEPTH=2, XU_COUNT=6 live in the shared package.
REQ-029 Scoreboard is sub-module issue_scoreboard, instantiated only under ISSUE_SCOREBOARD_EN.

Verification
REQ-030 Push {adder, tag 3, rd 5} at cycle 0, cur_tag 3, xu_busy 0 -> iss_valid=1, iss_sel=6'b000010, iss_tag 3 at cycle 2.
REQ-031 xu_busy[memory]=1 for 4 cycles with memory head -> no issue, stall_cnt=4, dec_ready 0 after second push; issue one cycle after busy drops.
REQ-032 Two entries with tag 2, cur_tag switched to 4 -> both popped on consecutive cycles, iss_valid never asserted, stall_cnt unchanged.
REQ-033 (scoreboard) Issue rd 7, then head rs1 7 -> blocked; wb_valid, wb_rd 7 at cycle k -> issue decided at cycle k+1, iss_valid at k+2.
REQ-034 reset at cycle 3 with occupancy 2 -> no iss_valid afterwards, dec_ready=1, stall_cnt=0 at cycle 4.
REQ-035 Force 65540 blocked cycles -> stall_cnt holds 16'hFFFF.
